// File: rtl/devil_pkg.sv
// rtl/devil_pkg.sv - shared constants and types for the devil snoop-response scheduler
//
// Purpose: CTRL.FUNC encodings, CTRL register bit positions and the scheduler
//          state type, shared by devil_cr_sched and the register file.
// Ports:   none (package).
package devil_pkg;

  // CTRL.FUNC encodings; any other value leaves snoops untouched.
  localparam logic [3:0] FUNC_OSH = 4'd0;
  localparam logic [3:0] FUNC_CON = 4'd1;

  // CTRL register bit positions (LSB of each field).
  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_TEST_BIT    = 1;
  localparam int CTRL_FUNC_BIT    = 5;
  localparam int CTRL_CRRESP_BIT  = 9;
  localparam int CTRL_ACFLT_BIT   = 14;
  localparam int CTRL_ADDRFLT_BIT = 15;
  localparam int CTRL_OSHEN_BIT   = 16;
  localparam int CTRL_CONEN_BIT   = 17;
  localparam int CTRL_DELAY_BIT   = 18;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/devil_addr_match.sv
// rtl/devil_addr_match.sv - combinational snoop address window check
//
// Purpose: addr_ok_o = base <= addr < base+size, computed one bit wider than
//          the AC address so base+size can never wrap. A zero size never matches.
// Ports:
//   addr_i     in  ADDR_W      snoop address
//   base_i     in  CFG_ADDR_W  window base (zero-extended)
//   size_i     in  CFG_ADDR_W  window size (zero-extended)
//   addr_ok_o  out 1           address lies inside the window
module devil_addr_match #(
  parameter int ADDR_W     = 44,
  parameter int CFG_ADDR_W = 32
) (
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [CFG_ADDR_W-1:0] base_i,
  input  logic [CFG_ADDR_W-1:0] size_i,
  output logic                  addr_ok_o
);

  localparam int XW = ADDR_W + 1;

  logic [XW-1:0] addr_x;
  logic [XW-1:0] base_x;
  logic [XW-1:0] end_x;

  assign addr_x = {1'b0, addr_i};
  assign base_x = XW'(base_i);
  assign end_x  = base_x + XW'(size_i);

  assign addr_ok_o = (size_i != '0) && (addr_x >= base_x) && (addr_x < end_x);

endmodule

// File: rtl/devil_cr_sched.sv
// rtl/devil_cr_sched.sv - ACE snoop-response scheduler with programmable delay and forced CRRESP
//
// Purpose: accepts one AC snoop at a time, classifies it against the acsnoop
//          and address filters, optionally holds it for cfg_delay cycles and
//          answers it on CR with either the forced cfg_crresp or zero. Every
//          accepted snoop is answered exactly once.
// Ports:
//   clk_100MHz, reset           clock, synchronous active-high reset
//   acvalid/acready/acaddr/acsnoop   AC snoop request channel
//   crvalid/crready/crresp           CR snoop response channel
//   cfg_*                       register-file configuration (CTRL, DELAY,
//                               ACSNOOP, BASE_ADDR, MEM_SIZE)
//   status_clr                  STATUS write-1 pulse
//   status_osh_done             sticky: one-shot has fired
//   status_hit_cnt              saturating count of delayed/forced responses
module devil_cr_sched
  import devil_pkg::*;
#(
  parameter int ADDR_W     = 44,
  parameter int SNOOP_W    = 4,
  parameter int CRRESP_W   = 5,
  parameter int DELAY_W    = 32,
  parameter int CFG_ADDR_W = 32,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_100MHz,
  input  logic                  reset,
  input  logic                  acvalid,
  output logic                  acready,
  input  logic [ADDR_W-1:0]     acaddr,
  input  logic [SNOOP_W-1:0]    acsnoop,
  output logic                  crvalid,
  input  logic                  crready,
  output logic [CRRESP_W-1:0]   crresp,
  input  logic                  cfg_en,
  input  logic [3:0]            cfg_func,
  input  logic [CRRESP_W-1:0]   cfg_crresp,
  input  logic                  cfg_acflt,
  input  logic                  cfg_addrflt,
  input  logic                  cfg_oshen,
  input  logic                  cfg_conen,
  input  logic [DELAY_W-1:0]    cfg_delay,
  input  logic [SNOOP_W-1:0]    cfg_acsnoop,
  input  logic [CFG_ADDR_W-1:0] cfg_base_addr,
  input  logic [CFG_ADDR_W-1:0] cfg_mem_size,
  input  logic                  status_clr,
  output logic                  status_osh_done,
  output logic [CNT_W-1:0]      status_hit_cnt
);

  state_e               state_q;
  logic                 acready_q;
  logic                 crvalid_q;
  logic [CRRESP_W-1:0]  crresp_q;
  logic [CRRESP_W-1:0]  resp_val_q;   // response captured at the AC handshake
  logic                 hit_q;
  logic                 osh_q;        // captured snoop was a one-shot hit
  logic [DELAY_W-1:0]   cnt_q;
  logic                 osh_done_q;
  logic                 osh_done_d;
  logic [CNT_W-1:0]     hit_cnt_q;
  logic [CNT_W-1:0]     hit_cnt_d;

  logic addr_ok;
  logic snoop_ok;
  logic armed;
  logic hit;
  logic ac_fire;
  logic cr_fire;
  logic set_hit;

  devil_addr_match #(
    .ADDR_W     (ADDR_W),
    .CFG_ADDR_W (CFG_ADDR_W)
  ) u_addr_match (
    .addr_i    (acaddr),
    .base_i    (cfg_base_addr),
    .size_i    (cfg_mem_size),
    .addr_ok_o (addr_ok)
  );

  assign armed = cfg_en &&
                 (((cfg_func == FUNC_OSH) && cfg_oshen && !osh_done_q) ||
                  ((cfg_func == FUNC_CON) && cfg_conen));
  assign snoop_ok = !cfg_acflt || (acsnoop == cfg_acsnoop);
  assign hit      = armed && snoop_ok && (!cfg_addrflt || addr_ok);

  assign ac_fire = (state_q == ST_IDLE) && acvalid && acready_q;
  assign cr_fire = (state_q == ST_RESP) && crvalid_q && crready;
  assign set_hit = cr_fire && hit_q;

  // Clear is applied first so a simultaneous set still lands (done=1, cnt=1).
  always_comb begin
    osh_done_d = osh_done_q;
    hit_cnt_d  = hit_cnt_q;
    if (status_clr) begin
      osh_done_d = 1'b0;
      hit_cnt_d  = '0;
    end
    if (set_hit && osh_q) begin
      osh_done_d = 1'b1;
    end
    if (set_hit && (hit_cnt_d != '1)) begin
      hit_cnt_d = hit_cnt_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      osh_done_q <= 1'b0;
      hit_cnt_q  <= '0;
    end else begin
      osh_done_q <= osh_done_d;
      hit_cnt_q  <= hit_cnt_d;
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      acready_q  <= 1'b0;
      crvalid_q  <= 1'b0;
      crresp_q   <= '0;
      resp_val_q <= '0;
      hit_q      <= 1'b0;
      osh_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ac_fire) begin
            acready_q  <= 1'b0;
            hit_q      <= hit;
            osh_q      <= hit && (cfg_func == FUNC_OSH);
            resp_val_q <= hit ? cfg_crresp : '0;
            // A zero delay answers on the same schedule as a miss.
            if (hit && (cfg_delay != '0)) begin
              state_q <= ST_DELAY;
              cnt_q   <= cfg_delay;
            end else begin
              state_q   <= ST_RESP;
              crvalid_q <= 1'b1;
              crresp_q  <= hit ? cfg_crresp : '0;
            end
          end else begin
            acready_q <= 1'b1;
          end
        end

        ST_DELAY: begin
          // Leave on the last counted cycle so crvalid rises exactly D
          // cycles after DELAY is entered; dropping cfg_en aborts early
          // but still answers with the captured response.
          if (!cfg_en || (cnt_q <= DELAY_W'(1))) begin
            state_q   <= ST_RESP;
            crvalid_q <= 1'b1;
            crresp_q  <= resp_val_q;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q - DELAY_W'(1);
          end
        end

        ST_RESP: begin
          if (cr_fire) begin
            state_q   <= ST_IDLE;
            crvalid_q <= 1'b0;
            crresp_q  <= '0;
            acready_q <= 1'b1;
            hit_q     <= 1'b0;
            osh_q     <= 1'b0;
          end
        end

        default: begin
          state_q   <= ST_IDLE;
          acready_q <= 1'b0;
          crvalid_q <= 1'b0;
          crresp_q  <= '0;
        end
      endcase
    end
  end

  assign acready         = acready_q;
  assign crvalid         = crvalid_q;
  assign crresp          = crresp_q;
  assign status_osh_done = osh_done_q;
  assign status_hit_cnt  = hit_cnt_q;

endmodule

// File: tb/tb_devil_cr_sched.sv
// tb/tb_devil_cr_sched.sv - directed vector bench for devil_cr_sched
module tb_devil_cr_sched;

  localparam int ADDR_W     = 44;
  localparam int SNOOP_W    = 4;
  localparam int CRRESP_W   = 5;
  localparam int DELAY_W    = 32;
  localparam int CFG_ADDR_W = 32;
  localparam int CNT_W      = 16;
  localparam logic [CRRESP_W-1:0] CRR = 5'h15;

  logic                  clk_100MHz = 1'b0;
  logic                  reset = 1'b1;
  logic                  acvalid = 1'b0;
  logic                  acready;
  logic [ADDR_W-1:0]     acaddr = '0;
  logic [SNOOP_W-1:0]    acsnoop = '0;
  logic                  crvalid;
  logic                  crready = 1'b1;
  logic [CRRESP_W-1:0]   crresp;
  logic                  cfg_en = 1'b0;
  logic [3:0]            cfg_func = 4'd0;
  logic [CRRESP_W-1:0]   cfg_crresp = CRR;
  logic                  cfg_acflt = 1'b0;
  logic                  cfg_addrflt = 1'b0;
  logic                  cfg_oshen = 1'b0;
  logic                  cfg_conen = 1'b0;
  logic [DELAY_W-1:0]    cfg_delay = '0;
  logic [SNOOP_W-1:0]    cfg_acsnoop = '0;
  logic [CFG_ADDR_W-1:0] cfg_base_addr = '0;
  logic [CFG_ADDR_W-1:0] cfg_mem_size = '0;
  logic                  status_clr = 1'b0;
  logic                  status_osh_done;
  logic [CNT_W-1:0]      status_hit_cnt;

  always #5 clk_100MHz = ~clk_100MHz;

  devil_cr_sched dut (
    .clk_100MHz      (clk_100MHz),
    .reset           (reset),
    .acvalid         (acvalid),
    .acready         (acready),
    .acaddr          (acaddr),
    .acsnoop         (acsnoop),
    .crvalid         (crvalid),
    .crready         (crready),
    .crresp          (crresp),
    .cfg_en          (cfg_en),
    .cfg_func        (cfg_func),
    .cfg_crresp      (cfg_crresp),
    .cfg_acflt       (cfg_acflt),
    .cfg_addrflt     (cfg_addrflt),
    .cfg_oshen       (cfg_oshen),
    .cfg_conen       (cfg_conen),
    .cfg_delay       (cfg_delay),
    .cfg_acsnoop     (cfg_acsnoop),
    .cfg_base_addr   (cfg_base_addr),
    .cfg_mem_size    (cfg_mem_size),
    .status_clr      (status_clr),
    .status_osh_done (status_osh_done),
    .status_hit_cnt  (status_hit_cnt)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  typedef struct {
    logic        en;
    logic [3:0]  func;
    logic        oshen;
    logic        conen;
    logic        acflt;
    logic        addrflt;
    logic [3:0]  fsnoop;
    logic [31:0] base;
    logic [31:0] size;
    logic [31:0] delay;
    logic [43:0] addr;
    logic [3:0]  snoop;
    logic        hit;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic apply_cfg(input vec_t v);
    cfg_en        = v.en;
    cfg_func      = v.func;
    cfg_oshen     = v.oshen;
    cfg_conen     = v.conen;
    cfg_acflt     = v.acflt;
    cfg_addrflt   = v.addrflt;
    cfg_acsnoop   = v.fsnoop;
    cfg_base_addr = v.base;
    cfg_mem_size  = v.size;
    cfg_delay     = v.delay;
  endtask

  // Issue one snoop and check latency from the AC handshake to crvalid,
  // the response value and the return to idle. Optionally pulses status_clr
  // in the same cycle as the CR handshake.
  task automatic snoop(input string name, input logic [43:0] addr, input logic [3:0] snp,
                       input int exp_lat, input logic [4:0] exp_resp, input logic clr_at_resp);
    int b;
    int lat;
    acaddr  = addr;
    acsnoop = snp;
    acvalid = 1'b1;
    crready = 1'b1;
    b = 0;
    while (!acready && b < 20) begin
      step();
      b++;
    end
    if (!acready) begin
      check({name, " acready timeout"}, 64'(acready), 64'd1);
      acvalid = 1'b0;
      return;
    end
    step();
    acvalid = 1'b0;
    lat = 1;
    while (!crvalid && lat < 2000) begin
      step();
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " crresp"}, 64'(crresp), 64'(exp_resp));
    if (clr_at_resp) status_clr = 1'b1;
    step();
    status_clr = 1'b0;
    check({name, " crvalid drop"}, 64'(crvalid), 64'd0);
    check({name, " crresp drop"}, 64'(crresp), 64'd0);
  endtask

  initial begin
    //        en   func  osh  con  acf  adf  fsn   base    size     delay    addr              snp  hit  lat
    vecs[0]  = '{1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0,  32'h0,   32'd5,   44'h123,          4'd0, 1'b1, 6};
    vecs[1]  = '{1'b1, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 32'h0,  32'h0,   32'd3,   44'h40,           4'd0, 1'b0, 1};
    vecs[2]  = '{1'b1, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 32'h0,  32'h0,   32'd3,   44'h40,           4'd1, 1'b1, 4};
    vecs[3]  = '{1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 32'h10, 32'h100, 32'd2,   44'h0F,           4'd0, 1'b0, 1};
    vecs[4]  = '{1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 32'h10, 32'h100, 32'd2,   44'h10,           4'd0, 1'b1, 3};
    vecs[5]  = '{1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 32'h10, 32'h100, 32'd2,   44'h10F,          4'd0, 1'b1, 3};
    vecs[6]  = '{1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 32'h10, 32'h100, 32'd2,   44'h110,          4'd0, 1'b0, 1};
    vecs[7]  = '{1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 32'h10, 32'h0,   32'd2,   44'h10,           4'd0, 1'b0, 1};
    vecs[8]  = '{1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 32'h10, 32'h100, 32'd2,   44'h1_0000_0010,  4'd0, 1'b0, 1};
    vecs[9]  = '{1'b1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0,  32'h0,   32'd2,   44'h10,           4'd0, 1'b0, 1};
    vecs[10] = '{1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0,  32'h0,   32'd2,   44'h10,           4'd0, 1'b0, 1};
    vecs[11] = '{1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0,  32'h0,   32'd0,   44'h10,           4'd0, 1'b1, 1};
    vecs[12] = '{1'b0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0,  32'h0,   32'd2,   44'h10,           4'd0, 1'b0, 1};
    vecs[13] = '{1'b1, 4'd1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd7, 32'h10, 32'h100, 32'd1,   44'h20,           4'd7, 1'b1, 2};

    // Reset state
    reset = 1'b1;
    step();
    step();
    check("reset acready", 64'(acready), 64'd0);
    check("reset crvalid", 64'(crvalid), 64'd0);
    check("reset crresp", 64'(crresp), 64'd0);
    check("reset done", 64'(status_osh_done), 64'd0);
    check("reset cnt", 64'(status_hit_cnt), 64'd0);
    reset = 1'b0;
    step();
    check("acready after reset", 64'(acready), 64'd1);

    // Table-driven vectors
    for (int i = 0; i < 14; i++) begin
      apply_cfg(vecs[i]);
      snoop($sformatf("vec%0d", i), vecs[i].addr, vecs[i].snoop, vecs[i].lat,
            vecs[i].hit ? CRR : 5'h0, 1'b0);
      if (vecs[i].hit) exp_cnt++;
      check($sformatf("vec%0d hit_cnt", i), 64'(status_hit_cnt), 64'(exp_cnt));
    end

    // One-shot sequence
    status_clr = 1'b1;
    step();
    status_clr = 1'b0;
    check("clr cnt", 64'(status_hit_cnt), 64'd0);
    cfg_en = 1'b1; cfg_func = 4'd0; cfg_oshen = 1'b1; cfg_conen = 1'b0;
    cfg_acflt = 1'b0; cfg_addrflt = 1'b0; cfg_delay = 32'd2;
    snoop("osh1", 44'h80, 4'd0, 3, CRR, 1'b0);
    check("osh1 done", 64'(status_osh_done), 64'd1);
    check("osh1 cnt", 64'(status_hit_cnt), 64'd1);
    snoop("osh2", 44'h80, 4'd0, 1, 5'h0, 1'b0);
    snoop("osh3", 44'h80, 4'd0, 1, 5'h0, 1'b0);
    check("osh3 cnt", 64'(status_hit_cnt), 64'd1);
    status_clr = 1'b1;
    step();
    status_clr = 1'b0;
    check("osh clr done", 64'(status_osh_done), 64'd0);
    check("osh clr cnt", 64'(status_hit_cnt), 64'd0);
    // Clear coincides with the CR handshake of a hit: set wins.
    snoop("osh4", 44'h80, 4'd0, 3, CRR, 1'b1);
    check("osh4 done set-wins", 64'(status_osh_done), 64'd1);
    check("osh4 cnt set-wins", 64'(status_hit_cnt), 64'd1);

    // Backpressure: forced zero-delay hit, crready low for 10 cycles
    cfg_func = 4'd1; cfg_conen = 1'b1; cfg_delay = 32'd0;
    acaddr = 44'h200; acvalid = 1'b1; crready = 1'b0;
    step();
    step();
    check("stall first crvalid", 64'(crvalid), 64'd1);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("stall%0d crvalid", k), 64'(crvalid), 64'd1);
      check($sformatf("stall%0d crresp", k), 64'(crresp), 64'(CRR));
      check($sformatf("stall%0d acready", k), 64'(acready), 64'd0);
      step();
    end
    acvalid = 1'b0;
    crready = 1'b1;
    step();
    check("stall release crvalid", 64'(crvalid), 64'd0);
    check("stall cnt", 64'(status_hit_cnt), 64'd2);

    // Abort: cfg_en dropped 3 cycles into a long delay
    cfg_delay = 32'd1000;
    acaddr = 44'h300; acvalid = 1'b1;
    step();
    step();
    acvalid = 1'b0;
    step(); step(); step();
    check("abort pre crvalid", 64'(crvalid), 64'd0);
    cfg_en = 1'b0;
    step();
    check("abort crvalid", 64'(crvalid), 64'd1);
    check("abort crresp", 64'(crresp), 64'(CRR));
    step();
    check("abort done crvalid", 64'(crvalid), 64'd0);
    check("abort cnt", 64'(status_hit_cnt), 64'd3);

    // Reset in the middle of a delay
    cfg_en = 1'b1;
    step();
    acvalid = 1'b1;
    step();
    step();
    acvalid = 1'b0;
    step(); step(); step();
    check("middelay crvalid", 64'(crvalid), 64'd0);
    check("middelay acready", 64'(acready), 64'd0);
    reset = 1'b1;
    step();
    check("midreset acready", 64'(acready), 64'd0);
    check("midreset crvalid", 64'(crvalid), 64'd0);
    check("midreset crresp", 64'(crresp), 64'd0);
    check("midreset done", 64'(status_osh_done), 64'd0);
    check("midreset cnt", 64'(status_hit_cnt), 64'd0);
    reset = 1'b0;
    step();
    check("post midreset acready", 64'(acready), 64'd1);
    check("post midreset crvalid", 64'(crvalid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
